l2_mem_miss_ctrl: RTL and testbench

- Cache-side initiator for the shared main-memory port. There is one instance per L2 cache.
- On an L2 miss it sequences an optional dirty-victim writeback, then a block read from main memory.
- It waits for the read acknowledge, the invalid-address flag, or a timeout, then returns the fill block, or an error, to the L2.
- Its outputs drive memory_read_n, memory_write_n, tag_n_L2, index_n_L2 and l2_cache_out_data_to_memory_n of the memory block.

---
 rtl/l2_mem_miss_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_l2_mem_miss_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_miss_ctrl.sv
// L2 miss controller: optional dirty-victim writeback, then a block read from
// main memory that ends in a fill, an invalid-address error or a timeout error.
module l2_mem_miss_ctrl #(
  parameter int unsigned index_bits     = 7,
  parameter int unsigned tag_bits       = 24,
  parameter int unsigned block_size     = 512,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_BITS       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [tag_bits-1:0]   miss_tag,
  input  logic [index_bits-1:0] miss_index,
  input  logic                  victim_dirty,
  input  logic [tag_bits-1:0]   victim_tag,
  input  logic [block_size-1:0] victim_data,
  output logic                  fill_valid,
  output logic                  fill_error,
  output logic                  fill_timeout,
  output logic [block_size-1:0] fill_data,
  output logic                  memory_read,
  output logic                  memory_write,
  output logic [tag_bits-1:0]   mem_tag,
  output logic [index_bits-1:0] mem_index,
  output logic [block_size-1:0] mem_wdata,
  input  logic [block_size-1:0] mem_rdata,
  input  logic                  mem_rd_ack,
  input  logic                  mem_invalid,
  output logic [CNT_BITS-1:0]   miss_count,
  output logic [CNT_BITS-1:0]   wb_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WB, RD, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [tag_bits-1:0]   tag_q, tag_d;
  logic [index_bits-1:0] index_q, index_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  fill_valid_q, fill_valid_d;
  logic                  fill_error_q, fill_error_d;
  logic                  fill_timeout_q, fill_timeout_d;
  logic [block_size-1:0] fill_data_q, fill_data_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [tag_bits-1:0]   mem_tag_q, mem_tag_d;
  logic [index_bits-1:0] mem_index_q, mem_index_d;
  logic [block_size-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_BITS-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_BITS-1:0]   wb_cnt_q, wb_cnt_d;
  logic                  ack_c, inv_c;

  // Only a solid 1 counts as a response; X/Z from the memory side is ignored.
  assign ack_c = (mem_rd_ack === 1'b1);
  assign inv_c = (mem_invalid === 1'b1);

  assign miss_ready = (state_q == IDLE) && RST;

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    index_d        = index_q;
    cnt_d          = cnt_q;
    fill_valid_d   = 1'b0;
    fill_error_d   = 1'b0;
    fill_timeout_d = 1'b0;
    fill_data_d    = fill_data_q;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    mem_tag_d      = mem_tag_q;
    mem_index_d    = mem_index_q;
    mem_wdata_d    = mem_wdata_q;
    miss_cnt_d     = miss_cnt_q;
    wb_cnt_d       = wb_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (miss_valid && miss_ready) begin
          tag_d       = miss_tag;
          index_d     = miss_index;
          cnt_d       = '0;
          mem_index_d = miss_index;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
          if (victim_dirty) begin
            state_d     = WB;
            mem_write_d = 1'b1;
            mem_tag_d   = victim_tag;
            mem_wdata_d = victim_data;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            mem_tag_d  = miss_tag;
          end
        end
      end
      WB: begin
        state_d     = RD;
        mem_read_d  = 1'b1;
        mem_tag_d   = tag_q;
        mem_index_d = index_q;
        cnt_d       = '0;
        if (wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + CNT_BITS'(1);
      end
      RD: begin
        cnt_d = cnt_q + TW'(1);
        if (ack_c) begin
          state_d      = DONE;
          fill_valid_d = 1'b1;
          fill_data_d  = mem_rdata;
        end else if (inv_c) begin
          state_d      = ERR;
          fill_valid_d = 1'b1;
          fill_error_d = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d        = ERR;
          fill_valid_d   = 1'b1;
          fill_error_d   = 1'b1;
          fill_timeout_d = 1'b1;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      tag_q          <= '0;
      index_q        <= '0;
      cnt_q          <= '0;
      fill_valid_q   <= 1'b0;
      fill_error_q   <= 1'b0;
      fill_timeout_q <= 1'b0;
      fill_data_q    <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_tag_q      <= '0;
      mem_index_q    <= '0;
      mem_wdata_q    <= '0;
      miss_cnt_q     <= '0;
      wb_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      index_q        <= index_d;
      cnt_q          <= cnt_d;
      fill_valid_q   <= fill_valid_d;
      fill_error_q   <= fill_error_d;
      fill_timeout_q <= fill_timeout_d;
      fill_data_q    <= fill_data_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_tag_q      <= mem_tag_d;
      mem_index_q    <= mem_index_d;
      mem_wdata_q    <= mem_wdata_d;
      miss_cnt_q     <= miss_cnt_d;
      wb_cnt_q       <= wb_cnt_d;
    end
  end

  assign fill_valid   = fill_valid_q;
  assign fill_error   = fill_error_q;
  assign fill_timeout = fill_timeout_q;
  assign fill_data    = fill_data_q;
  assign memory_read  = mem_read_q;
  assign memory_write = mem_write_q;
  assign mem_tag      = mem_tag_q;
  assign mem_index    = mem_index_q;
  assign mem_wdata    = mem_wdata_q;
  assign miss_count   = miss_cnt_q;
  assign wb_count     = wb_cnt_q;

endmodule

// File: tb/tb_l2_mem_miss_ctrl.sv
// Scoreboard bench for l2_mem_miss_ctrl: a driver issues misses and plays the
// memory, a monitor checks writeback pulses and fills against queued results.
module tb_l2_mem_miss_ctrl;

  localparam int unsigned T = 8;

  logic         CLK, RST;
  logic         miss_valid, miss_ready;
  logic [23:0]  miss_tag, victim_tag, mem_tag;
  logic [6:0]   miss_index, mem_index;
  logic         victim_dirty;
  logic [511:0] victim_data, fill_data, mem_wdata, mem_rdata;
  logic         fill_valid, fill_error, fill_timeout;
  logic         memory_read, memory_write, mem_rd_ack, mem_invalid;
  logic [15:0]  miss_count, wb_count;

  l2_mem_miss_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_tag(miss_tag), .miss_index(miss_index),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
    .fill_valid(fill_valid), .fill_error(fill_error), .fill_timeout(fill_timeout),
    .fill_data(fill_data),
    .memory_read(memory_read), .memory_write(memory_write),
    .mem_tag(mem_tag), .mem_index(mem_index), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd_ack(mem_rd_ack), .mem_invalid(mem_invalid),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         err;
    logic         to;
    logic [511:0] data;
    logic [15:0]  mc;
    logic [15:0]  wc;
  } fill_t;

  typedef struct {
    logic [23:0]  tag;
    logic [6:0]   idx;
    logic [511:0] data;
  } wr_t;

  fill_t fq[$];
  wr_t   wq[$];

  int vectors = 0;
  int errors  = 0;

  // Reference model state: what the L2 has seen so far
  logic [511:0] m_last = '0;
  logic [15:0]  m_mc = '0;
  logic [15:0]  m_wc = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every fill strobe and writeback pulse must match a queued expectation
  initial begin
    fill_t f;
    wr_t   w;
    forever begin
      @(posedge CLK);
      #1;
      if (fill_valid) begin
        if (fq.size() == 0) chk("unexpected_fill", 512'(fill_valid), 512'(0));
        else begin
          f = fq.pop_front();
          chk("fill_error", 512'(fill_error), 512'(f.err));
          chk("fill_timeout", 512'(fill_timeout), 512'(f.to));
          chk("fill_data", fill_data, f.data);
          chk("miss_count", 512'(miss_count), 512'(f.mc));
          chk("wb_count", 512'(wb_count), 512'(f.wc));
          chk("ready_in_fill", 512'(miss_ready), 512'(0));
        end
      end
      if (memory_write) begin
        chk("rw_exclusive", 512'(memory_read), 512'(0));
        if (wq.size() == 0) chk("unexpected_write", 512'(memory_write), 512'(0));
        else begin
          w = wq.pop_front();
          chk("wb_tag", 512'(mem_tag), 512'(w.tag));
          chk("wb_index", 512'(mem_index), 512'(w.idx));
          chk("wb_data", mem_wdata, w.data);
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_ready", 512'(miss_ready), 512'(0));
    chk("rst_read", 512'(memory_read), 512'(0));
    chk("rst_write", 512'(memory_write), 512'(0));
    chk("rst_fill_valid", 512'(fill_valid), 512'(0));
    chk("rst_fill_data", fill_data, 512'(0));
    chk("rst_miss_count", 512'(miss_count), 512'(0));
    chk("rst_wb_count", 512'(wb_count), 512'(0));
  endtask

  // mode: 0 ack, 1 invalid, 2 no response, 3 ack+invalid together, 4 reset while reading
  task automatic do_miss(input logic [23:0] t, input logic [6:0] ix, input bit dirty,
                         input logic [23:0] vt, input logic [511:0] vd,
                         input int mode, input int ridx, input logic [511:0] rd, input bit hold);
    fill_t f;
    wr_t   w;
    int    rd_n;
    int    exp_rd;
    bit    ended;
    for (int k = 0; k < 20 && !miss_ready; k++) @(negedge CLK);
    chk("miss_ready", 512'(miss_ready), 512'(1));

    m_mc = m_mc + 16'd1;
    if (dirty) begin
      m_wc = m_wc + 16'd1;
      w.tag = vt; w.idx = ix; w.data = vd;
      wq.push_back(w);
    end
    f.mc = m_mc; f.wc = m_wc;
    case (mode)
      1:       begin f.err = 1'b1; f.to = 1'b0; f.data = m_last; exp_rd = ridx + 1; end
      2:       begin f.err = 1'b1; f.to = 1'b1; f.data = m_last; exp_rd = T; end
      default: begin f.err = 1'b0; f.to = 1'b0; f.data = rd; m_last = rd; exp_rd = ridx + 1; end
    endcase
    if (mode != 4) fq.push_back(f);

    miss_valid = 1'b1; miss_tag = t; miss_index = ix;
    victim_dirty = dirty; victim_tag = vt; victim_data = vd;
    rd_n = 0;
    ended = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(negedge CLK);
      if (c >= 2 || !hold) miss_valid = 1'b0;
      miss_tag = 24'($urandom); victim_dirty = 1'($urandom);
      mem_rd_ack = 1'b0; mem_invalid = 1'b0;
      mem_rdata = rand512();
      if (memory_read) begin
        if (rd_n == 0) chk("rd_latency", 512'(c), 512'(dirty ? 2 : 1));
        if (rd_n == 0) chk("rd_tag", 512'(mem_tag), 512'(t));
        if (rd_n == 0) chk("rd_index", 512'(mem_index), 512'(ix));
        if (mode == 4 && rd_n == 2) begin
          RST = 1'b0;
          ended = 1'b1;
          break;
        end
        if (rd_n == ridx && mode != 2) begin
          if (mode == 0 || mode == 3) begin mem_rd_ack = 1'b1; mem_rdata = rd; end
          if (mode == 1 || mode == 3) mem_invalid = 1'b1;
        end
        rd_n++;
      end else if (rd_n > 0) begin
        ended = 1'b1;
        break;
      end
    end
    chk("read_ended", 512'(ended), 512'(1));

    if (mode == 4) begin
      fq.delete();
      m_mc = '0; m_wc = '0; m_last = '0;
      @(posedge CLK);
      #1;
      check_reset_state();
      repeat (2) @(negedge CLK);
      RST = 1'b1;
    end else begin
      chk("rd_cycles", 512'(rd_n), 512'(exp_rd));
      for (int k = 0; k < 4 && fq.size() != 0; k++) @(negedge CLK);
      chk("fill_drained", 512'(fq.size()), 512'(0));
    end
  endtask

  initial begin
    RST = 1'b0; miss_valid = 1'b0; miss_tag = '0; miss_index = '0;
    victim_dirty = 1'b0; victim_tag = '0; victim_data = '0;
    mem_rdata = '0; mem_rd_ack = 1'b0; mem_invalid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state();
    @(negedge CLK);
    RST = 1'b1;

    do_miss(24'h000012, 7'h05, 1'b0, '0, '0, 0, 2, {16{32'hA5A5A5A5}}, 1'b0);
    do_miss(24'h000012, 7'h05, 1'b1, 24'h0000AB, {16{32'h5A5A5A5A}}, 0, 0, rand512(), 1'b0);
    do_miss(24'h000034, 7'h11, 1'b0, '0, '0, 1, 1, rand512(), 1'b0);
    do_miss(24'h000056, 7'h22, 1'b0, '0, '0, 2, 0, rand512(), 1'b0);
    do_miss(24'h000078, 7'h33, 1'b0, '0, '0, 3, 0, rand512(), 1'b0);
    do_miss(24'h00009A, 7'h44, 1'b1, 24'h0000CD, rand512(), 1, T - 1, rand512(), 1'b1);
    do_miss(24'h0000BC, 7'h55, 1'b0, '0, '0, 0, T - 1, rand512(), 1'b1);

    for (int n = 0; n < 40; n++)
      do_miss(24'($urandom), 7'($urandom), 1'($urandom), 24'($urandom), rand512(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, T - 1)), rand512(),
              1'($urandom));

    do_miss(24'h0000EE, 7'h66, 1'b1, 24'h0000DD, rand512(), 4, 0, rand512(), 1'b0);
    do_miss(24'h000012, 7'h05, 1'b0, '0, '0, 0, 1, rand512(), 1'b0);

    repeat (3) @(negedge CLK);
    chk("no_pending_writes", 512'(wq.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
